// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 5-stage 32-bit RISC pipeline.
//   XLEN              datapath / address width
//   RESET_PC_DEFAULT  first fetch address after reset
//   NOP_INSTR_DEFAULT encoding used for pipeline bubbles (addi x0,x0,0)
//   if_id_t           IF/ID pipeline word
//   fetch_entry_t     one fetched {pc, instr} pair held in the skid buffer
package cpu_pkg;

    localparam int          XLEN              = 32;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry synchronous FIFO of {pc, instr} pairs that absorbs
// instruction responses arriving while decode is stalled.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; empties the FIFO
//   i_push       write i_push_data at the tail
//   i_pop        drop the head entry (caller guarantees non-empty)
//   i_clear      empties the FIFO; takes priority over push and pop
//   i_push_data  entry to write
//   o_count      number of valid entries (0..2)
//   o_head       oldest entry (meaningful only when o_count != 0)
module fetch_skid_fifo
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  fetch_entry_t i_push_data,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && !i_clear;
    assign w_do_pop  = i_pop  && !i_clear;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; entries are only observed once counted.
    always_ff @(posedge clk) begin
        if (!reset && w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

`ifndef SYNTHESIS
    // The fetch unit's issue throttle must keep occupancy within two slots.
    always @(posedge clk) begin
        if (!reset && w_do_push)
            assert (r_count != 2'd2) else $error("fetch_skid_fifo: push while full");
    end
`endif

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage. Owns the PC, drives the synchronous
// instruction memory (1-cycle read latency), and presents a registered IF/ID
// word to decode. A 2-entry skid buffer absorbs decode stalls; an EX redirect
// flushes everything in flight.
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   read_addr        address to instruction memory (the PC register)
//   instr_in         memory data for the previous cycle's read_addr
//   stall            decode cannot accept; IF/ID holds
//   redirect_valid   branch/jump taken in EX
//   redirect_pc      redirect target (low two bits ignored)
//   if_id_valid      IF/ID holds a real instruction
//   if_id_instr      fetched instruction, NOP_INSTR on a bubble
//   if_id_pc         address of if_id_instr
//   if_id_pc_plus4   if_id_pc + 4
//
// Handshake toward decode: the IF/ID word is offered every cycle; decode
// consumes it on any cycle where stall is low. While stall is high the word
// and all of if_id_* are held unchanged (except on redirect, which forces a
// bubble). Toward memory there is no handshake: every read_addr is answered
// exactly one cycle later, so fetching is throttled by counting outstanding
// slots (buffered entries + the response in flight) against the 2-entry buffer.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN      = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] read_addr,
    input  logic [XLEN-1:0] instr_in,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus4
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;      // address whose response is in flight
    logic            r_inflight;
    if_id_t          r_if_id;
    logic [XLEN-1:0] r_if_id_pc4;

    logic [1:0]      w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;
    logic [2:0]      w_occupancy;
    logic            w_issue;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    if_id_t          w_if_id_next;
    logic [XLEN-1:0] w_pc4_next;

    assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight};

    // Unstalled: the head drains every cycle, so fetching can always continue.
    // Stalled: only fetch if the response will still find a free slot.
    assign w_issue = !redirect_valid && (!stall || (w_occupancy < 3'd2));

    // A response goes straight to IF/ID only if nothing older is buffered.
    assign w_bypass    = r_inflight && !stall && (w_count == 2'd0);
    assign w_push      = r_inflight && !w_bypass;
    assign w_pop       = !stall && (w_count != 2'd0);
    assign w_push_data = '{pc: r_req_pc, instr: instr_in};

    fetch_skid_fifo u_skid (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_clear     (redirect_valid),
        .i_push_data (w_push_data),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_inflight <= 1'b0;
        end else if (redirect_valid) begin
            r_pc       <= {redirect_pc[XLEN-1:2], 2'b00};
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_pc       <= r_pc + XLEN'(4);
            r_req_pc   <= r_pc;
            r_inflight <= 1'b1;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    always_comb begin
        w_if_id_next = r_if_id;
        w_pc4_next   = r_if_id_pc4;
        if (redirect_valid) begin
            w_if_id_next.valid = 1'b0;
            w_if_id_next.instr = NOP_INSTR;
        end else if (!stall) begin
            if (w_count != 2'd0) begin
                w_if_id_next = '{valid: 1'b1, pc: w_head.pc, instr: w_head.instr};
                w_pc4_next   = w_head.pc + XLEN'(4);
            end else if (r_inflight) begin
                w_if_id_next = '{valid: 1'b1, pc: r_req_pc, instr: instr_in};
                w_pc4_next   = r_req_pc + XLEN'(4);
            end else begin
                // Bubble keeps the last pc so decode sees a stable address.
                w_if_id_next.valid = 1'b0;
                w_if_id_next.instr = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_id     <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
            r_if_id_pc4 <= XLEN'(4);
        end else begin
            r_if_id     <= w_if_id_next;
            r_if_id_pc4 <= w_pc4_next;
        end
    end

    assign read_addr      = r_pc;
    assign if_id_valid    = r_if_id.valid;
    assign if_id_instr    = r_if_id.instr;
    assign if_id_pc       = r_if_id.pc;
    assign if_id_pc_plus4 = r_if_id_pc4;

endmodule
